// File: rtl/lm70_pkg.sv
// Shared constants, FSM state type and helpers for the LM70 SPI temperature reader.
package lm70_pkg;

   localparam int unsigned NBITS     = 16;
   localparam int unsigned MSB_W     = 8;
   localparam int unsigned BIT_CNT_W = $clog2(NBITS);
   localparam int unsigned DIV_CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      SCK_HI,
      SCK_LO,
      GAP
   } lm70_state_e;

   // Signed greater-than on two's-complement bytes.
   function automatic logic signed_gt(input logic [MSB_W-1:0] a, input logic [MSB_W-1:0] b);
      return $signed(a) > $signed(b);
   endfunction

endpackage

// File: rtl/lm70_sck_gen.sv
// Half-period counter and SCK toggle; phase_done_o marks the last clk cycle of each phase.
module lm70_sck_gen
   import lm70_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   output logic sck_o,
   output logic phase_done_o
);

   logic [DIV_CNT_W-1:0] cnt_q;
   logic                 sck_q;
   logic                 phase_done_q;

   // Count clk cycles within a phase; the strobe is registered one cycle early so it
   // is high during the final cycle of the phase, and sck flips on that same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         sck_q        <= 1'b0;
         phase_done_q <= 1'b0;
      end else if (!run_i) begin
         cnt_q        <= '0;
         sck_q        <= 1'b0;
         phase_done_q <= 1'b0;
      end else begin
         if (phase_done_q) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         phase_done_q <= (cnt_q == DIV_CNT_W'(CLK_DIV - 2));
      end
   end

   assign sck_o        = sck_q;
   assign phase_done_o = phase_done_q;

endmodule

// File: rtl/lm70_spi_reader.sv
// LM70 temperature sensor reader: one 16-bit SPI read per start, with over-temp compare.
module lm70_spi_reader
   import lm70_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CS_GAP  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sio_in,
   output logic             cs,
   output logic             sck,
   output logic             busy,
   output logic             temp_valid,
   output logic [NBITS-1:0] temp_data,
   output logic [MSB_W-1:0] temp_msb,
   input  logic [MSB_W-1:0] thresh,
   output logic             over_temp
);

   localparam int unsigned GAP_W = (CS_GAP < 2) ? 1 : $clog2(CS_GAP);

   lm70_state_e          state_q;
   logic                 cs_q;
   logic                 busy_q;
   logic                 temp_valid_q;
   logic [NBITS-1:0]     temp_data_q;
   logic                 over_temp_q;
   logic [NBITS-1:0]     shift_q;
   logic [BIT_CNT_W-1:0] bit_cnt_q;
   logic [GAP_W-1:0]     gap_cnt_q;
   logic                 sck_run_c;
   logic                 phase_done;

   // The SCK generator runs only while cs is low.
   assign sck_run_c = (state_q == LEAD) || (state_q == SCK_HI) || (state_q == SCK_LO);

   lm70_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk          (clk),
      .rst          (rst),
      .run_i        (sck_run_c),
      .sck_o        (sck),
      .phase_done_o (phase_done)
   );

   // Transaction sequencing, MSB-first shift-in and result capture on the edge raising cs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cs_q         <= 1'b1;
         busy_q       <= 1'b0;
         temp_valid_q <= 1'b0;
         temp_data_q  <= '0;
         over_temp_q  <= 1'b0;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
      end else begin
         temp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  cs_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  bit_cnt_q <= '0;
                  state_q   <= LEAD;
               end
            end
            LEAD, SCK_LO: begin
               // Sample on the edge that raises sck.
               if (phase_done) begin
                  shift_q <= {shift_q[NBITS-2:0], sio_in};
                  state_q <= SCK_HI;
               end
            end
            SCK_HI: begin
               if (phase_done) begin
                  if (bit_cnt_q == BIT_CNT_W'(NBITS - 1)) begin
                     cs_q         <= 1'b1;
                     temp_data_q  <= shift_q;
                     over_temp_q  <= signed_gt(shift_q[NBITS-1 -: MSB_W], thresh);
                     temp_valid_q <= 1'b1;
                     gap_cnt_q    <= '0;
                     state_q      <= GAP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     state_q   <= SCK_LO;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_W'(CS_GAP - 1)) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cs         = cs_q;
   assign busy       = busy_q;
   assign temp_valid = temp_valid_q;
   assign temp_data  = temp_data_q;
   assign temp_msb   = temp_data_q[NBITS-1 -: MSB_W];
   assign over_temp  = over_temp_q;

endmodule

// File: tb/tb_lm70_spi_reader.sv
// Self-checking bench for lm70_spi_reader with a behavioural LM70 sensor model.
module tb_lm70_spi_reader;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned CS_GAP  = 8;
   localparam int          NB      = 16;
   localparam int          CS_LOW_CYCLES = 2 * NB * CLK_DIV;
   localparam int          READ_LIMIT    = 400;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sio_in;
   logic [7:0]  thresh;
   logic        cs;
   logic        sck;
   logic        busy;
   logic        temp_valid;
   logic [15:0] temp_data;
   logic [7:0]  temp_msb;
   logic        over_temp;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lm70_spi_reader #(
      .CLK_DIV (CLK_DIV),
      .CS_GAP  (CS_GAP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .sio_in     (sio_in),
      .cs         (cs),
      .sck        (sck),
      .busy       (busy),
      .temp_valid (temp_valid),
      .temp_data  (temp_data),
      .temp_msb   (temp_msb),
      .thresh     (thresh),
      .over_temp  (over_temp)
   );

   // Sensor model: word presented MSB first from cs fall, next bit after each sck fall.
   logic [15:0] sensor_word = 16'h0000;
   int sck_falls  = 0;
   int frame_base = 0;
   int cs_falls   = 0;
   int sck_rises  = 0;

   function automatic logic sensor_bit(input logic [15:0] w, input int k);
      logic [15:0] t;
      t = w;
      if (k < 0 || k > 15) return 1'b0;
      return t[15-k];
   endfunction

   assign sio_in = sensor_bit(sensor_word, sck_falls - frame_base);

   always @(negedge sck) sck_falls++;
   always @(posedge sck) sck_rises++;
   always @(negedge cs) begin
      frame_base = sck_falls;
      cs_falls++;
   end

   // Interval monitor sampled mid-cycle: cs low/high run lengths and temp_valid pulses.
   int tv_pulses = 0;
   int low_run   = 0;
   int high_run  = 0;
   int last_low  = 0;
   int last_high = 0;

   always @(negedge clk) begin
      if (temp_valid === 1'b1) tv_pulses++;
      if (cs === 1'b0) begin
         if (high_run != 0) last_high = high_run;
         high_run = 0;
         low_run++;
      end else begin
         if (low_run != 0) last_low = low_run;
         low_run = 0;
         high_run++;
      end
   end

   // Reference: interpret the upper byte and threshold as signed integers.
   function automatic int sbyte(input logic [7:0] b);
      return (b >= 8'd128) ? int'(b) - 256 : int'(b);
   endfunction

   function automatic logic model_over(input logic [15:0] w, input logic [7:0] t);
      return sbyte(w[15:8]) > sbyte(t);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Full read from a negedge: pulse start, wait for busy to drop, check every result.
   task automatic do_read(input logic [15:0] w, input logic [7:0] t, input string tag);
      int  s0;
      int  tv0;
      bit  done;
      sensor_word = w;
      thresh      = t;
      s0          = sck_rises;
      tv0         = tv_pulses;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_cs_fall"}, 32'(cs), 32'd0);
      done = 1'b0;
      for (int i = 0; i < READ_LIMIT && !done; i++) begin
         @(negedge clk);
         if (busy === 1'b0) done = 1'b1;
      end
      check({tag, "_finished"}, 32'(done), 32'd1);
      check({tag, "_sck_rises"}, 32'(sck_rises - s0), 32'd16);
      check({tag, "_valid_pulses"}, 32'(tv_pulses - tv0), 32'd1);
      check({tag, "_data"}, 32'(temp_data), 32'(w));
      check({tag, "_msb"}, 32'(temp_msb), 32'(w[15:8]));
      check({tag, "_over"}, 32'(over_temp), 32'(model_over(w, t)));
      check({tag, "_cs_low_len"}, 32'(last_low), 32'(CS_LOW_CYCLES));
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [15:0] w1;
      logic [15:0] w2;
      logic [7:0]  t1;
      int          f0;
      int          tv0;
      int          s0;
      bit          ok;

      rst    = 1'b1;
      start  = 1'b0;
      thresh = 8'h00;

      // Start during reset must be ignored.
      repeat (3) @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cs", 32'(cs), 32'd1);
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(temp_valid), 32'd0);
      check("rst_data", 32'(temp_data), 32'd0);
      check("rst_over", 32'(over_temp), 32'd0);
      start = 1'b0;

      // Release reset and request on the very first edge afterwards.
      rst = 1'b0;
      do_read(16'h0033, 8'h00, "r0033");

      // Started in the first cycle busy is low; checks the minimum cs gap too.
      do_read(16'hA5C3, 8'h10, "rA5C3");
      check("gap_min", 32'(last_high >= int'(CS_GAP)), 32'd1);

      do_read(16'h3200, 8'h18, "r3200_t18");
      do_read(16'h3200, 8'h32, "r3200_t32");

      // Start pulses mid-frame and during the gap are dropped.
      w1 = 16'($urandom);
      t1 = 8'($urandom);
      sensor_word = w1;
      thresh      = t1;
      f0  = cs_falls;
      tv0 = tv_pulses;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_data_held", 32'(temp_data), 32'h3200);
      check("busy_cs_low", 32'(cs), 32'd0);
      ok = 1'b0;
      for (int i = 0; i < READ_LIMIT && !ok; i++) begin
         @(negedge clk);
         if (tv_pulses > tv0) ok = 1'b1;
      end
      check("busy_valid_seen", 32'(ok), 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < READ_LIMIT && !ok; i++) begin
         @(negedge clk);
         if (busy === 1'b0) ok = 1'b1;
      end
      check("busy_finished", 32'(ok), 32'd1);
      repeat (20) @(negedge clk);
      check("busy_one_frame", 32'(cs_falls - f0), 32'd1);
      check("busy_one_valid", 32'(tv_pulses - tv0), 32'd1);
      check("busy_data", 32'(temp_data), 32'(w1));
      check("busy_over", 32'(over_temp), 32'(model_over(w1, t1)));

      // Abort after the 7th sck rise: reset acts without waiting for a clock edge.
      w2 = 16'($urandom);
      sensor_word = w2;
      s0  = sck_rises;
      tv0 = tv_pulses;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < READ_LIMIT && !ok; i++) begin
         @(negedge clk);
         if (sck_rises - s0 >= 7) ok = 1'b1;
      end
      check("abort_reached_7", 32'(ok), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_cs", 32'(cs), 32'd1);
      check("abort_sck", 32'(sck), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_data", 32'(temp_data), 32'd0);
      check("abort_over", 32'(over_temp), 32'd0);
      repeat (3) @(negedge clk);
      check("abort_no_valid", 32'(tv_pulses - tv0), 32'd0);
      check("abort_sck_count", 32'(sck_rises - s0), 32'd7);
      rst = 1'b0;
      do_read(16'($urandom), 8'($urandom), "after_abort");

      // Threshold equal to the upper byte is not over temperature.
      w1 = 16'($urandom);
      do_read(w1, w1[15:8], "equal_thresh");

      for (int n = 0; n < 6; n++) begin
         do_read(16'($urandom), 8'($urandom), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
